// File: rtl/mem_port_pkg.sv
// Shared types and constants for the unified-memory access port.
package mem_port_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    // Defaults shared with the datapath.
    localparam int DEF_AW      = 32;
    localparam int DEF_DW      = 32;
    localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/wait_timer.sv
// Saturating wait-cycle counter; flags the last permitted wait cycle.
// Latency: expired is combinational from the count; count updates on the clock edge.
// Backpressure: none; clear has priority over en, and TIMEOUT=0 never expires.
module wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != SAT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && (count == LAST);

endmodule

// File: rtl/mem_port.sv
// Unified-memory port: one word fetch/load/store per request into instr/data registers.
// Latency: 2 cycles plus one per mem_ready-low cycle in BUSY; back-to-back requests allowed.
// Backpressure: stall held while busy or errored; misalignment and timeout lock into ERR.
module mem_port
    import mem_port_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic          irwrite,
    input  logic [AW-1:0] adr,
    input  logic [DW-1:0] wd,
    output logic          stall,
    output logic [DW-1:0] instr,
    output logic [DW-1:0] data,
    output logic          err,
    output logic          mem_valid,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata
);

    state_t state;
    logic   op_we;
    logic   op_ir;
    logic   tmr_clear;
    logic   tmr_en;
    logic   tmr_expired;

    // Counter sits at zero whenever not waiting, so every access starts fresh.
    assign tmr_clear = (state != ST_BUSY);
    assign tmr_en    = (state == ST_BUSY) && !mem_ready;

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    assign stall = (state == ST_BUSY) || (state == ST_ERR) || ((state == ST_IDLE) && req);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            instr     <= '0;
            data      <= '0;
            err       <= 1'b0;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_adr   <= '0;
            mem_wdata <= '0;
            op_we     <= 1'b0;
            op_ir     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        if ((adr[1:0] & WORD_ALIGN_MASK) != 2'b00) begin
                            err   <= 1'b1;
                            state <= ST_ERR;
                        end else begin
                            mem_adr   <= adr;
                            mem_wdata <= wd;
                            mem_we    <= we;
                            op_we     <= we;
                            op_ir     <= irwrite;
                            mem_valid <= 1'b1;
                            state     <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    // Completion takes priority over a timeout in the same cycle.
                    if (mem_ready) begin
                        if (!op_we) begin
                            if (op_ir) begin
                                instr <= mem_rdata;
                            end else begin
                                data <= mem_rdata;
                            end
                        end
                        mem_valid <= 1'b0;
                        mem_we    <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (tmr_expired) begin
                        err       <= 1'b1;
                        mem_valid <= 1'b0;
                        mem_we    <= 1'b0;
                        state     <= ST_ERR;
                    end
                end
                ST_ERR: begin
                    mem_valid <= 1'b0;
                    mem_we    <= 1'b0;
                end
                default: begin
                    state <= ST_ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port.sv
// Directed bench for mem_port: fetch, load with waits, store, misalign, timeout, async reset.
module tb_mem_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic        irwrite;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        stall;
    logic [31:0] instr;
    logic [31:0] data;
    logic        err;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    mem_port #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .irwrite   (irwrite),
        .adr       (adr),
        .wd        (wd),
        .stall     (stall),
        .instr     (instr),
        .data      (data),
        .err       (err),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive inputs 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample outputs on the falling edge.
    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; req = 1'b0; we = 1'b0; irwrite = 1'b0;
        adr = '0; wd = '0; mem_ready = 1'b0; mem_rdata = '0;

        #3;
        chk1("rst_valid", mem_valid, 1'b0);
        chk1("rst_stall", stall, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_we", mem_we, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_data", data, 32'h0);
        chk("rst_adr", mem_adr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        mid();
        rst = 1'b1;

        // Fetch, zero-wait memory
        tick();
        req = 1'b1; irwrite = 1'b1; we = 1'b0; adr = 32'h0000_0004; mem_rdata = 32'h2008_0005;
        mid();
        chk1("f_c0_stall", stall, 1'b1);
        chk1("f_c0_valid", mem_valid, 1'b0);
        tick();
        req = 1'b0; mem_ready = 1'b1;
        mid();
        chk1("f_c1_valid", mem_valid, 1'b1);
        chk1("f_c1_stall", stall, 1'b1);
        chk1("f_c1_we", mem_we, 1'b0);
        chk("f_c1_adr", mem_adr, 32'h0000_0004);
        tick();
        mem_ready = 1'b0;
        mid();
        chk("f_instr", instr, 32'h2008_0005);
        chk1("f_c2_stall", stall, 1'b0);
        chk1("f_c2_valid", mem_valid, 1'b0);
        chk("f_data", data, 32'h0);

        // Load with 3 wait cycles
        tick();
        req = 1'b1; irwrite = 1'b0; adr = 32'h0000_0040; mem_rdata = 32'hDEAD_BEEF;
        lat = 0;
        mid();
        if (stall) lat++;
        tick();
        req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            if (stall) lat++;
            chk1("ld_wait_valid", mem_valid, 1'b1);
            chk("ld_wait_adr", mem_adr, 32'h0000_0040);
            tick();
        end
        mem_ready = 1'b1;
        mid();
        if (stall) lat++;
        chk("ld_done_adr", mem_adr, 32'h0000_0040);
        tick();
        mem_ready = 1'b0;
        mid();
        chk1("ld_stall_end", stall, 1'b0);
        chk("ld_latency", lat, 32'd5);
        chk("ld_data", data, 32'hDEAD_BEEF);
        chk("ld_instr_kept", instr, 32'h2008_0005);

        // Store; read data on the bus must not be captured
        tick();
        req = 1'b1; we = 1'b1; adr = 32'h0000_0080; wd = 32'h1234_5678;
        mid();
        tick();
        req = 1'b0; we = 1'b0; wd = 32'h0; mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
        mid();
        chk1("st_valid", mem_valid, 1'b1);
        chk1("st_we", mem_we, 1'b1);
        chk("st_wdata", mem_wdata, 32'h1234_5678);
        chk("st_adr", mem_adr, 32'h0000_0080);
        tick();
        mem_ready = 1'b0;
        mid();
        chk1("st_we_off", mem_we, 1'b0);
        chk("st_instr", instr, 32'h2008_0005);
        chk("st_data", data, 32'hDEAD_BEEF);

        // Ready exactly on the 15th BUSY cycle completes normally
        tick();
        req = 1'b1; adr = 32'h0000_0100; mem_rdata = 32'hCAFE_0001;
        mid();
        tick();
        req = 1'b0;
        for (int i = 0; i < 14; i++) begin
            mid();
            chk1("edge_valid", mem_valid, 1'b1);
            tick();
        end
        mem_ready = 1'b1;
        mid();
        chk1("edge_c15_err", err, 1'b0);
        tick();
        mem_ready = 1'b0;
        mid();
        chk1("edge_err", err, 1'b0);
        chk("edge_data", data, 32'hCAFE_0001);
        chk1("edge_stall", stall, 1'b0);

        // Misaligned request
        tick();
        req = 1'b1; adr = 32'h0000_0042;
        mid();
        chk1("mis_c0_valid", mem_valid, 1'b0);
        chk1("mis_c0_err", err, 1'b0);
        tick();
        req = 1'b0;
        mid();
        chk1("mis_err", err, 1'b1);
        chk1("mis_valid", mem_valid, 1'b0);
        chk1("mis_stall", stall, 1'b1);
        tick();
        req = 1'b1; adr = 32'h0000_0044;
        mid();
        tick();
        req = 1'b0;
        mid();
        chk1("err_ignores_req", mem_valid, 1'b0);
        chk1("err_sticky", err, 1'b1);
        chk("err_data_hold", data, 32'hCAFE_0001);

        // Reset clears ERR
        #2;
        rst = 1'b0;
        #1;
        chk1("rst2_err", err, 1'b0);
        chk1("rst2_stall", stall, 1'b0);
        #1;
        rst = 1'b1;

        // Timeout: ready held low
        tick();
        req = 1'b1; adr = 32'h0000_0200;
        mid();
        tick();
        req = 1'b0;
        for (int i = 0; i < 15; i++) begin
            mid();
            chk1("to_wait_valid", mem_valid, 1'b1);
            tick();
        end
        mid();
        chk1("to_err", err, 1'b1);
        chk1("to_valid", mem_valid, 1'b0);
        chk1("to_stall", stall, 1'b1);

        // Reset, load then start a fetch and abort it with reset mid-BUSY
        #2;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        tick();
        req = 1'b1; irwrite = 1'b0; adr = 32'h0000_0010; mem_rdata = 32'h3333_4444;
        tick();
        req = 1'b0; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        mid();
        chk("pre_rst_data", data, 32'h3333_4444);
        tick();
        req = 1'b1; irwrite = 1'b1; adr = 32'h0000_0008;
        tick();
        req = 1'b0;
        mid();
        chk1("pre_rst_valid", mem_valid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk1("arst_valid", mem_valid, 1'b0);
        chk1("arst_stall", stall, 1'b0);
        chk("arst_instr", instr, 32'h0);
        chk("arst_data", data, 32'h0);
        #1;
        rst = 1'b1;

        // Fresh fetch after reset
        tick();
        req = 1'b1; irwrite = 1'b1; adr = 32'h0000_0004; mem_rdata = 32'h0000_ABCD;
        tick();
        req = 1'b0; mem_ready = 1'b1;
        mid();
        chk1("post_valid", mem_valid, 1'b1);
        tick();
        mem_ready = 1'b0;
        mid();
        chk("post_instr", instr, 32'h0000_ABCD);
        chk1("post_stall", stall, 1'b0);
        chk1("post_err", err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
